// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register.
// Covers control-word field widths, NOP encodings and the per-edge action decode.
package id_ex_pipe_reg_pkg;

  localparam int ALU_OP_W     = 3;
  localparam int MEM_TO_REG_W = 2;
  localparam int REG_IDX_W    = 5;
  localparam int FUNCT_W      = 4;

  localparam logic [ALU_OP_W-1:0]     ALU_OP_NOP     = 3'b000;
  localparam logic [MEM_TO_REG_W-1:0] MEM_TO_REG_ALU = 2'b00;

  typedef struct packed {
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    alu_src;
    logic [MEM_TO_REG_W-1:0] mem_to_reg;
    logic [ALU_OP_W-1:0]     alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    alu_src:    1'b0,
    mem_to_reg: MEM_TO_REG_ALU,
    alu_op:     ALU_OP_NOP
  };

  typedef enum logic [1:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_STALL,
    ACT_LOAD
  } action_e;

  // Exactly one action per edge; reset beats flush beats stall.
  function automatic action_e decode_action(input logic rst, input logic flush,
                                            input logic stall);
    action_e act;
    if (rst)        act = ACT_RESET;
    else if (flush) act = ACT_FLUSH;
    else if (stall) act = ACT_STALL;
    else            act = ACT_LOAD;
    return act;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Saturating up-counter used for the bubble and flush performance counts.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hold, flush-to-NOP and bubble tagging.
// Also counts captured bubbles and applied flushes with saturating counters.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    bubble_i,
  input  logic                    regWrite_i,
  input  logic                    memRead_i,
  input  logic                    memWrite_i,
  input  logic                    ALUSrc_i,
  input  logic [MEM_TO_REG_W-1:0] memtoReg_i,
  input  logic [ALU_OP_W-1:0]     ALUOp_i,
  input  logic [DATA_W-1:0]       pc_i,
  input  logic [DATA_W-1:0]       rs1_data_i,
  input  logic [DATA_W-1:0]       rs2_data_i,
  input  logic [DATA_W-1:0]       imm_i,
  input  logic [REG_IDX_W-1:0]    rs1_i,
  input  logic [REG_IDX_W-1:0]    rs2_i,
  input  logic [REG_IDX_W-1:0]    rd_i,
  input  logic [FUNCT_W-1:0]      funct_i,
  output logic                    regWrite_o,
  output logic                    memRead_o,
  output logic                    memWrite_o,
  output logic                    ALUSrc_o,
  output logic [MEM_TO_REG_W-1:0] memtoReg_o,
  output logic [ALU_OP_W-1:0]     ALUOp_o,
  output logic [DATA_W-1:0]       pc_o,
  output logic [DATA_W-1:0]       rs1_data_o,
  output logic [DATA_W-1:0]       rs2_data_o,
  output logic [DATA_W-1:0]       imm_o,
  output logic [REG_IDX_W-1:0]    rs1_o,
  output logic [REG_IDX_W-1:0]    rs2_o,
  output logic [REG_IDX_W-1:0]    rd_o,
  output logic [FUNCT_W-1:0]      funct_o,
  output logic                    valid_o,
  output logic [CNT_W-1:0]        bubble_cnt_o,
  output logic [CNT_W-1:0]        flush_cnt_o
);

  action_e action;
  ctrl_t   ctrl_in;
  ctrl_t   ctrl_q;

  logic [DATA_W-1:0]    pc_q;
  logic [DATA_W-1:0]    rs1_data_q;
  logic [DATA_W-1:0]    rs2_data_q;
  logic [DATA_W-1:0]    imm_q;
  logic [REG_IDX_W-1:0] rs1_q;
  logic [REG_IDX_W-1:0] rs2_q;
  logic [REG_IDX_W-1:0] rd_q;
  logic [FUNCT_W-1:0]   funct_q;
  logic                 valid_q;

  assign action = decode_action(rst_i, flush_i, stall_i);

  assign ctrl_in = '{
    reg_write:  regWrite_i,
    mem_read:   memRead_i,
    mem_write:  memWrite_i,
    alu_src:    ALUSrc_i,
    mem_to_reg: memtoReg_i,
    alu_op:     ALUOp_i
  };

  always_ff @(posedge clk_i) begin
    case (action)
      ACT_RESET, ACT_FLUSH: begin
        ctrl_q     <= CTRL_NOP;
        pc_q       <= '0;
        rs1_data_q <= '0;
        rs2_data_q <= '0;
        imm_q      <= '0;
        rs1_q      <= '0;
        rs2_q      <= '0;
        rd_q       <= '0;
        funct_q    <= '0;
        valid_q    <= 1'b0;
      end
      ACT_LOAD: begin
        // Bubble control bits arrive already zeroed; only rd needs clearing
        // so forwarding can never match a bubble.
        ctrl_q     <= ctrl_in;
        pc_q       <= pc_i;
        rs1_data_q <= rs1_data_i;
        rs2_data_q <= rs2_data_i;
        imm_q      <= imm_i;
        rs1_q      <= rs1_i;
        rs2_q      <= rs2_i;
        rd_q       <= bubble_i ? '0 : rd_i;
        funct_q    <= funct_i;
        valid_q    <= ~bubble_i;
      end
      default: ;
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i ((action == ACT_LOAD) && bubble_i),
    .cnt_o (bubble_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (action == ACT_FLUSH),
    .cnt_o (flush_cnt_o)
  );

  assign regWrite_o = ctrl_q.reg_write;
  assign memRead_o  = ctrl_q.mem_read;
  assign memWrite_o = ctrl_q.mem_write;
  assign ALUSrc_o   = ctrl_q.alu_src;
  assign memtoReg_o = ctrl_q.mem_to_reg;
  assign ALUOp_o    = ctrl_q.alu_op;
  assign pc_o       = pc_q;
  assign rs1_data_o = rs1_data_q;
  assign rs2_data_o = rs2_data_q;
  assign imm_o      = imm_q;
  assign rs1_o      = rs1_q;
  assign rs2_o      = rs2_q;
  assign rd_o       = rd_q;
  assign funct_o    = funct_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg (CNT_W=4 so saturation is reachable).
// Driver pushes one expectation per edge; the monitor pops and compares after each edge.
module tb_id_ex_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, bubble;
  logic        reg_write, mem_read, mem_write, alu_src;
  logic [1:0]  mem_to_reg;
  logic [2:0]  alu_op;
  logic [31:0] pc, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  funct;

  logic        o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_valid;
  logic [1:0]  o_mem_to_reg;
  logic [2:0]  o_alu_op;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [3:0]  o_funct, o_bcnt, o_fcnt;

  id_ex_pipe_reg #(.DATA_W(32), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .bubble_i(bubble),
    .regWrite_i(reg_write), .memRead_i(mem_read), .memWrite_i(mem_write),
    .ALUSrc_i(alu_src), .memtoReg_i(mem_to_reg), .ALUOp_i(alu_op),
    .pc_i(pc), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .imm_i(imm),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .funct_i(funct),
    .regWrite_o(o_reg_write), .memRead_o(o_mem_read), .memWrite_o(o_mem_write),
    .ALUSrc_o(o_alu_src), .memtoReg_o(o_mem_to_reg), .ALUOp_o(o_alu_op),
    .pc_o(o_pc), .rs1_data_o(o_rs1_data), .rs2_data_o(o_rs2_data), .imm_o(o_imm),
    .rs1_o(o_rs1), .rs2_o(o_rs2), .rd_o(o_rd), .funct_o(o_funct),
    .valid_o(o_valid), .bubble_cnt_o(o_bcnt), .flush_cnt_o(o_fcnt)
  );

  typedef struct packed {
    logic        reg_write, mem_read, mem_write, alu_src;
    logic [1:0]  mem_to_reg;
    logic [2:0]  alu_op;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  funct;
    logic        valid;
    logic [3:0]  bcnt, fcnt;
  } out_t;

  typedef struct {
    string name;
    out_t  e;
    out_t  m;
  } chk_t;

  chk_t q[$];
  out_t act;
  out_t mdl = '0;
  int   checks = 0;
  int   failures = 0;

  assign act = {o_reg_write, o_mem_read, o_mem_write, o_alu_src, o_mem_to_reg, o_alu_op,
                o_pc, o_rs1_data, o_rs2_data, o_imm, o_rs1, o_rs2, o_rd, o_funct,
                o_valid, o_bcnt, o_fcnt};

  // Monitor: one expectation per edge, compared under its mask.
  always @(posedge clk) begin
    chk_t c;
    #1;
    if (q.size() > 0) begin
      c = q.pop_front();
      if (c.m != '0) begin
        checks++;
        if ((act & c.m) != (c.e & c.m)) begin
          failures++;
          $display("FAIL %s actual=%h required=%h mask=%h", c.name, act, c.e, c.m);
        end
      end
    end
    checks++;
    if (!o_valid && (o_mem_write || o_reg_write)) begin
      failures++;
      $display("FAIL invalid_entry_writes actual memWrite=%0b regWrite=%0b required 0/0",
               o_mem_write, o_reg_write);
    end
  end

  task automatic model_step();
    out_t n;
    n = mdl;
    if (rst) begin
      n = '0;
    end else if (flush) begin
      n = '0;
      n.bcnt = mdl.bcnt;
      n.fcnt = (mdl.fcnt == 4'hF) ? 4'hF : mdl.fcnt + 4'd1;
    end else if (!stall) begin
      n.reg_write = reg_write; n.mem_read = mem_read; n.mem_write = mem_write;
      n.alu_src = alu_src; n.mem_to_reg = mem_to_reg; n.alu_op = alu_op;
      n.pc = pc; n.rs1_data = rs1_data; n.rs2_data = rs2_data; n.imm = imm;
      n.rs1 = rs1; n.rs2 = rs2; n.rd = bubble ? 5'd0 : rd; n.funct = funct;
      n.valid = ~bubble;
      if (bubble && mdl.bcnt != 4'hF) n.bcnt = mdl.bcnt + 4'd1;
    end
    mdl = n;
  endtask

  task automatic cyc(input string name, input out_t e, input out_t m, input bit use_model);
    chk_t c;
    model_step();
    c.name = name;
    if (use_model) begin
      c.e = mdl;
      c.m = '1;
    end else begin
      c.e = e;
      c.m = m;
    end
    q.push_back(c);
    @(negedge clk);
  endtask

  task automatic clr_in();
    rst = 0; stall = 0; flush = 0; bubble = 0;
    reg_write = 0; mem_read = 0; mem_write = 0; alu_src = 0;
    mem_to_reg = '0; alu_op = '0; pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;
    rs1 = '0; rs2 = '0; rd = '0; funct = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t e, m;
    rst = 1; stall = 1; flush = 1; bubble = 1;
    reg_write = 1; mem_read = 1; mem_write = 1; alu_src = 1;
    mem_to_reg = '1; alu_op = '1; pc = '1; rs1_data = '1; rs2_data = '1; imm = '1;
    rs1 = '1; rs2 = '1; rd = '1; funct = '1;

    e = '0; m = '1;
    cyc("reset_0", e, m, 0);
    cyc("reset_1", e, m, 0);

    clr_in(); pc = 32'h40;
    e = '0; e.pc = 32'h40; e.valid = 1; m = '1;
    cyc("first_load", e, m, 0);

    clr_in(); rd = 5; alu_op = 3'b010;
    e = '0; m = '0;
    e.rd = 5; m.rd = '1; e.alu_op = 3'b010; m.alu_op = '1; e.valid = 1; m.valid = '1;
    cyc("load_rd5", e, m, 0);
    stall = 1; rd = 7; alu_op = 3'b111;
    for (int i = 0; i < 3; i++) cyc("stall_hold", e, m, 0);
    stall = 0;
    e.rd = 7; e.alu_op = 3'b111;
    cyc("stall_release", e, m, 0);

    clr_in(); bubble = 1; rd = 9; pc = 32'h80;
    e = '0; m = '0;
    m.rd = '1; m.valid = '1; e.bcnt = 1; m.bcnt = '1; e.pc = 32'h80; m.pc = '1;
    cyc("bubble", e, m, 0);
    stall = 1; pc = 32'h88;
    cyc("bubble_stall", e, m, 0);

    clr_in(); flush = 1; stall = 1; mem_write = 1; rd = 3; pc = 32'h99;
    e = '0; e.bcnt = 1; e.fcnt = 1; m = '1;
    cyc("flush_over_stall", e, m, 0);

    clr_in(); mem_write = 1; rd = 3; funct = 4'hA; imm = 32'h1234;
    e = '0; e.mem_write = 1; e.rd = 3; e.funct = 4'hA; e.imm = 32'h1234;
    e.valid = 1; e.bcnt = 1; e.fcnt = 1; m = '1;
    cyc("store_load", e, m, 0);

    clr_in(); flush = 1;
    for (int k = 0; k < 20; k++) begin
      e = '0; m = '0;
      e.fcnt = (k + 2 > 15) ? 4'hF : 4'(k + 2); m.fcnt = '1; m.valid = '1;
      cyc("flush_saturate", e, m, 0);
    end
    clr_in(); rst = 1;
    e = '0; m = '1;
    cyc("reset_after_sat", e, m, 0);

    for (int n = 0; n < 300; n++) begin
      rst    = ($urandom_range(0, 31) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      bubble = ($urandom_range(0, 3) == 0);
      reg_write  = bubble ? 1'b0 : 1'($urandom);
      mem_read   = bubble ? 1'b0 : 1'($urandom);
      mem_write  = bubble ? 1'b0 : 1'($urandom);
      alu_src    = bubble ? 1'b0 : 1'($urandom);
      mem_to_reg = bubble ? 2'b00 : 2'($urandom);
      alu_op     = bubble ? 3'b000 : 3'($urandom);
      pc = $urandom; rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom); funct = 4'($urandom);
      cyc("random_stream", e, m, 1);
    end

    clr_in();
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
